// File: rtl/rv_mul_unit.sv
// rtl/rv_mul_unit.sv - iterative shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU
//
// Purpose: computes the 2*XLEN-bit product of two XLEN-bit operands, one bit per
//          cycle, on magnitudes. It applies the sign at the end and returns the
//          low or high half selected by op.
// Ports:
//   clk     in   1     clock, rising edge
//   rst     in   1     asynchronous active-high reset
//   start   in   1     request, sampled only in IDLE
//   kill    in   1     flush, aborts an op in progress / blocks acceptance
//   op      in   2     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a       in   XLEN  rs1 operand
//   b       in   XLEN  rs2 operand
//   busy    out  1     op running
//   done    out  1     one-cycle result-valid pulse
//   result  out  XLEN  selected product slice, held until next completion
module rv_mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int             CW   = $clog2(XLEN + 1);
  localparam logic [CW-1:0]  LAST = CW'(XLEN - 1);

  logic [0:0]        state;
  // Accumulator: upper XLEN+1 bits collect partial sums, lower XLEN bits
  // initially hold the multiplier and are shifted out one bit per step.
  logic [2*XLEN:0]   acc;
  logic [XLEN-1:0]   mcand;
  logic [CW-1:0]     cnt;
  logic              neg;
  logic [1:0]        op_q;

  // Operand sign handling at acceptance.
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;

  always_comb begin
    a_neg = (op == 2'b01 || op == 2'b10) && a[XLEN-1];
    b_neg = (op == 2'b01) && b[XLEN-1];
    // Two's-complement negate; the most-negative value maps onto 2^(XLEN-1),
    // which still fits in the unsigned XLEN-bit magnitude.
    a_mag = a_neg ? (~a + XLEN'(1)) : a;
    b_mag = b_neg ? (~b + XLEN'(1)) : b;
  end

  // One iteration step.
  logic [XLEN:0]     upper;
  logic [XLEN:0]     upper_sum;
  logic [2*XLEN:0]   acc_step;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_signed;

  always_comb begin
    upper       = acc[2*XLEN:XLEN];
    upper_sum   = acc[0] ? (upper + {1'b0, mcand}) : upper;
    acc_step    = {1'b0, upper_sum, acc[XLEN-1:1]};
    prod        = acc_step[2*XLEN-1:0];
    prod_signed = neg ? (~prod + (2*XLEN)'(1)) : prod;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      op_q   <= 2'b00;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !kill) begin
            state <= RUN;
            busy  <= 1'b1;
            op_q  <= op;
            neg   <= a_neg ^ b_neg;
            mcand <= a_mag;
            acc   <= {{(XLEN+1){1'b0}}, b_mag};
            cnt   <= '0;
          end
        end
        default: begin
          if (kill) begin
            // Abort: no done pulse, result keeps the previous op's value.
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              state  <= IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= (op_q == 2'b00) ? prod_signed[XLEN-1:0]
                                        : prod_signed[2*XLEN-1:XLEN];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mul_unit.sv
// tb/tb_rv_mul_unit.sv - self-checking bench for rv_mul_unit
module tb_rv_mul_unit;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            kill;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;

  rv_mul_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: sign- or zero-extend to 2*XLEN, multiply, pick the half.
  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] o, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
    logic [63:0] ex, ey, p;
    ex = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
    ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
    p  = ex * ey;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Wait (from a negedge) until done is seen at a negedge; n counts negedges
  // since the accepting edge, starting from n0. Bounded.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Launch one op from a negedge, check latency, busy and result.
  task automatic run_check(input string name, input logic [1:0] o, input logic [XLEN-1:0] x,
                           input logic [XLEN-1:0] y, input logic [XLEN-1:0] exp);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, " busy_after_accept"}, busy, 1);
    wait_done(1, n);
    check({name, " latency"}, n, LAT);
    check({name, " result"}, result, exp);
    check({name, " busy_in_done"}, busy, 0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [XLEN-1:0] held;

    vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42};
    vecs[1]  = '{2'b00, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE};
    vecs[2]  = '{2'b01, 32'h80000000,   32'h80000000,   32'h40000000};
    vecs[3]  = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000};
    vecs[4]  = '{2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF};
    vecs[5]  = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE};
    vecs[6]  = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF};
    vecs[7]  = '{2'b10, 32'd2,          32'h80000000,   32'h00000001};
    vecs[8]  = '{2'b00, 32'd0,          32'h12345678,   32'd0};
    vecs[9]  = '{2'b01, 32'd0,          32'hFFFFFFFB,   32'd0};
    vecs[10] = '{2'b00, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1};
    vecs[11] = '{2'b01, 32'h80000000,   32'd1,          32'hFFFFFFFF};
    vecs[12] = '{2'b11, 32'h80000000,   32'd2,          32'h00000001};
    vecs[13] = '{2'b00, 32'h80000000,   32'h80000000,   32'h00000000};

    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table.
    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]      ro;
      logic [XLEN-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 0) ra = 32'h80000000;
      if (i % 8 == 1) rb = 32'hFFFFFFFF;
      run_check($sformatf("rand%0d", i), ro, ra, rb, ref_mul(ro, ra, rb));
    end

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    op = 2'b00; a = 32'd3; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_reset busy", busy, 0);
    check("midrun_reset done", done, 0);
    check("midrun_reset result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_check("after_reset", 2'b00, 32'd11, 32'd13, 32'd143);

    // Start held high through busy: only one op.
    @(negedge clk);
    op = 2'b00; a = 32'd100; b = 32'd5; start = 1'b1;
    pulses = 0;
    n = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 30) start = 1'b0;
      if (done) begin
        pulses++;
        if (n == 0) n = c;
      end
    end
    check("held_start pulses", pulses, 1);
    check("held_start latency", n, LAT);
    check("held_start result", result, 500);

    // Back-to-back: start in the done cycle.
    run_check("b2b_first", 2'b01, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
    op = 2'b00; a = 32'd1000; b = 32'd1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b done_drops", done, 0);
    check("b2b busy", busy, 1);
    wait_done(1, n);
    check("b2b latency", n, LAT);
    check("b2b result", result, 32'd1000000);

    // Operands changed after E0 have no effect.
    @(negedge clk);
    op = 2'b10; a = 32'hFFFFFFF0; b = 32'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'b00; a = $urandom; b = $urandom;
    wait_done(1, n);
    check("opchange latency", n, LAT);
    check("opchange result", result, ref_mul(2'b10, 32'hFFFFFFF0, 32'd16));

    // Kill in RUN: no done, result unchanged.
    held = result;
    @(negedge clk);
    op = 2'b00; a = 32'd77; b = 32'd77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill busy", busy, 0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("kill no_done", pulses, 0);
    check("kill result_held", result, held);

    // Kill with start in IDLE: not accepted.
    op = 2'b00; a = 32'd2; b = 32'd2; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_idle busy", busy, 0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("kill_idle no_done", pulses, 0);
    check("kill_idle result", result, held);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
